// File: rtl/tpu_pkg.sv
// ============================================================================
// Module   : tpu_pkg
// Purpose  : Shared types and constants for the PE array and its feeders.
//            Holds the input-skew FSM state encoding and the default
//            activation width shared with processing_element.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package tpu_pkg;

    // Default activation width; processing_element a_in uses the same value.
    localparam int c_DATA_W = 8;

    // Input skew feeder states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        FULL = 3'd2,
        FEED = 3'd3,
        DONE = 3'd4
    } skew_state_t;

    // Address width for an n-entry array, never less than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : tpu_pkg

`default_nettype wire

// File: rtl/systolic_input_skew_buffer.sv
// ============================================================================
// Module   : skew_tile_buffer
// Purpose  : NxN activation tile register file. One row-wide write port and
//            N independent read ports; read port i returns element i of the
//            row it addresses, so every lane can look at a different row.
// Ports    : clk       clock
//            i_we      write enable
//            i_waddr   row index to write
//            i_wdata   row data, element i at [i*DATA_W +: DATA_W]
//            i_raddr   per-lane row index, lane i at [i*RW +: RW]
//            o_rdata   per-lane element, lane i at [i*DATA_W +: DATA_W]
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module skew_tile_buffer
    import tpu_pkg::*;
#(
    parameter int N      = 2,
    parameter int DATA_W = c_DATA_W,
    parameter int RW     = addr_w(N)
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [RW-1:0]       i_waddr,
    input  logic [N*DATA_W-1:0] i_wdata,
    input  logic [N*RW-1:0]     i_raddr,
    output logic [N*DATA_W-1:0] o_rdata
);

    // Tile contents carry no reset: a tile is always fully rewritten
    // before it is fed, so stale data is never observed.
    logic [N*DATA_W-1:0] r_mem [N];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_rd
        assign o_rdata[i*DATA_W +: DATA_W] =
            r_mem[i_raddr[i*RW +: RW]][i*DATA_W +: DATA_W];
    end

endmodule : skew_tile_buffer

`default_nettype wire

// File: rtl/systolic_input_skew.sv
// ============================================================================
// Module   : systolic_input_skew
// Purpose  : Upstream feeder for the weight-stationary PE array. Collects one
//            NxN activation tile row by row from a valid/ready source, then
//            on start drives the left-edge PE inputs with a diagonal skew:
//            lane i lags lane 0 by i cycles.
// Ports    : clk         clock
//            reset       asynchronous active-high reset
//            in_valid    source row valid
//            in_ready    block can accept a row (decoded from state only)
//            in_data     tile row, element i at [i*DATA_W +: DATA_W]
//            start       begin feeding the buffered tile (honoured in FULL)
//            busy        high in LOAD, FULL and FEED
//            done        one-cycle pulse after the last lane output
//            a_out       lane i at [i*DATA_W +: DATA_W] -> row-i PE a_in
//            lane_valid  lane i -> valid of every PE in array row i
// Config   : SKEW_ZERO_FILL_EN defined   -> lanes outside their window drive 0
//            SKEW_ZERO_FILL_EN undefined -> lanes hold their last value
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module systolic_input_skew
    import tpu_pkg::*;
#(
    parameter int N      = 2,
    parameter int DATA_W = c_DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DATA_W-1:0] in_data,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [N*DATA_W-1:0] a_out,
    output logic [N-1:0]        lane_valid
);

    localparam int CW = $clog2(2 * N);
    localparam int RW = addr_w(N);

    localparam logic [CW-1:0] c_T_LAST   = CW'(2 * N - 2);
    localparam logic [CW-1:0] c_ROW_LAST = CW'(N - 1);
    localparam logic [CW-1:0] c_N        = CW'(N);

    skew_state_t   r_state;
    logic [CW-1:0] r_row_cnt;
    logic [CW-1:0] r_t;

    logic                w_accept;
    logic [CW-1:0]       w_t_sel;
    logic [N-1:0]        w_in_win;
    logic [N*RW-1:0]     w_raddr;
    logic [N*DATA_W-1:0] w_rdata;
    logic [N*DATA_W-1:0] w_a_next;

    assign in_ready = (r_state == IDLE) || (r_state == LOAD);
    assign w_accept = in_valid && in_ready;

    // Outputs are registered, so the lane values loaded at a clock edge must
    // correspond to the step that becomes visible after that edge: step 0
    // when leaving FULL, otherwise the step after the current one.
    assign w_t_sel = (r_state == FULL) ? '0 : (r_t + CW'(1));

    skew_tile_buffer #(
        .N      (N),
        .DATA_W (DATA_W),
        .RW     (RW)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr (RW'(r_row_cnt)),
        .i_wdata (in_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Lane i shows row (t - i) while that row index lies in [0, N).
    for (genvar i = 0; i < N; i++) begin : g_lane
        localparam logic [CW-1:0] c_LANE = CW'(i);

        assign w_in_win[i] = (w_t_sel >= c_LANE) && ((w_t_sel - c_LANE) < c_N);
        assign w_raddr[i*RW +: RW] = RW'(w_t_sel - c_LANE);

`ifdef SKEW_ZERO_FILL_EN
        assign w_a_next[i*DATA_W +: DATA_W] =
            w_in_win[i] ? w_rdata[i*DATA_W +: DATA_W] : '0;
`else
        assign w_a_next[i*DATA_W +: DATA_W] =
            w_in_win[i] ? w_rdata[i*DATA_W +: DATA_W] : a_out[i*DATA_W +: DATA_W];
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_row_cnt  <= '0;
            r_t        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            a_out      <= '0;
            lane_valid <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE, LOAD: begin
                    // start is deliberately not examined here, even on the
                    // cycle that completes the tile.
                    if (w_accept) begin
                        busy <= 1'b1;
                        if (r_row_cnt == c_ROW_LAST) begin
                            r_state   <= FULL;
                            r_row_cnt <= '0;
                        end else begin
                            r_state   <= LOAD;
                            r_row_cnt <= r_row_cnt + CW'(1);
                        end
                    end
                end

                FULL: begin
                    if (start) begin
                        r_state    <= FEED;
                        r_t        <= '0;
                        a_out      <= w_a_next;
                        lane_valid <= w_in_win;
                    end
                end

                FEED: begin
                    // Lanes past their window either zero or hold; the final
                    // step therefore still loads w_a_next.
                    a_out <= w_a_next;
                    if (r_t == c_T_LAST) begin
                        r_state    <= DONE;
                        r_t        <= '0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        lane_valid <= '0;
                    end else begin
                        r_t        <= r_t + CW'(1);
                        lane_valid <= w_in_win;
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state    <= IDLE;
                    r_row_cnt  <= '0;
                    r_t        <= '0;
                    busy       <= 1'b0;
                    lane_valid <= '0;
                end
            endcase
        end
    end

endmodule : systolic_input_skew

`default_nettype wire

// File: tb/tb_systolic_input_skew.sv
// ============================================================================
// Module   : tb_systolic_input_skew
// Purpose  : Self-checking bench for systolic_input_skew (N=2, DATA_W=8).
//            Stimulus pushes the expected lane outputs of every feed into a
//            scoreboard queue; a monitor on the falling clock edge pops and
//            compares whenever the DUT presents lane_valid or done.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_systolic_input_skew;

    localparam int N  = 2;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] in_data;
    logic            start;
    logic            busy;
    logic            done;
    logic [N*DW-1:0] a_out;
    logic [N-1:0]    lane_valid;

    systolic_input_skew #(
        .N      (N),
        .DATA_W (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .a_out      (a_out),
        .lane_valid (lane_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N*DW-1:0] a;
        logic [N-1:0]    lv;
        logic            dn;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

`ifdef SKEW_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    // Last values driven on each lane (the hold-build idle value).
    logic [DW-1:0] h0 = '0;
    logic [DW-1:0] h1 = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented lane/done cycle must match the next expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset !== 1'b1 && (lane_valid !== '0 || done !== 1'b0)) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {29'd0, lane_valid, done}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("a_out", {16'd0, a_out}, {16'd0, e.a});
                check("lane_valid", {30'd0, lane_valid}, {30'd0, e.lv});
                check("done", {31'd0, done}, {31'd0, e.dn});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected output of one feed of tile {a,b},{c,d}; n_ent limits the
    // entries for a feed that will be cut short by reset.
    task automatic push_feed(input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [DW-1:0] c, input logic [DW-1:0] d,
                             input int n_ent);
        exp_t e [4];
        e[0] = '{a: {(ZF ? 8'd0 : h1), a}, lv: 2'b01, dn: 1'b0};
        e[1] = '{a: {b, c},                lv: 2'b11, dn: 1'b0};
        e[2] = '{a: {d, (ZF ? 8'd0 : c)}, lv: 2'b10, dn: 1'b0};
        e[3] = '{a: (ZF ? 16'd0 : {d, c}), lv: 2'b00, dn: 1'b1};
        for (int j = 0; j < n_ent; j++) sb.push_back(e[j]);
        if (n_ent == 4) begin
            h0 = ZF ? 8'd0 : c;
            h1 = ZF ? 8'd0 : d;
        end
    endtask

    task automatic send_row(input logic [DW-1:0] a, input logic [DW-1:0] b);
        bit ok = 1'b0;
        in_data  = {b, a};
        in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (in_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!ok) check("row_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done;
        bit seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("busy_in_done", {31'd0, busy}, 32'd0);
            check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
            tick();
            check("in_ready_after_done", {31'd0, in_ready}, 32'd1);
        end
    endtask

    task automatic run_feed(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] c, input logic [DW-1:0] d);
        push_feed(a, b, c, d, 4);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_a_out"}, {16'd0, a_out}, 32'd0);
        check({tag, "_lane_valid"}, {30'd0, lane_valid}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        start    = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();
        check_idle_outputs("post_reset");

        // Basic tile: skewed outputs and done pulse.
        send_row(8'd1, 8'd2);
        check("busy_load", {31'd0, busy}, 32'd1);
        send_row(8'd3, 8'd4);
        check("in_ready_full", {31'd0, in_ready}, 32'd0);
        check("busy_full", {31'd0, busy}, 32'd1);
        run_feed(8'd1, 8'd2, 8'd3, 8'd4);

        // Same tile again: idle lanes show their previously driven values.
        send_row(8'd1, 8'd2);
        send_row(8'd3, 8'd4);
        run_feed(8'd1, 8'd2, 8'd3, 8'd4);

        // in_valid held high; start on the cycle of the 2nd accept.
        in_valid = 1'b1;
        in_data  = {8'd10, 8'd9};
        tick();
        in_data  = {8'd12, 8'd11};
        start    = 1'b1;
        tick();
        start    = 1'b0;
        in_data  = {8'hAA, 8'h99};
        for (int n = 0; n < 3; n++) begin
            check("in_ready_full_hold", {31'd0, in_ready}, 32'd0);
            tick();
        end
        push_feed(8'd9, 8'd10, 8'd11, 8'd12, 4);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("in_ready_feed", {31'd0, in_ready}, 32'd0);
        tick();
        start = 1'b1;                 // must not restart the feed
        tick();
        start = 1'b0;
        wait_done();
        in_valid = 1'b0;
        tick();
        tick();
        check("no_third_row", {31'd0, busy}, 32'd0);

        // Reset in FEED at t=1 abandons the tile.
        send_row(8'd13, 8'd14);
        send_row(8'd15, 8'd16);
        push_feed(8'd13, 8'd14, 8'd15, 8'd16, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        h0 = '0;
        h1 = '0;
        tick();
        check_idle_outputs("mid_reset");
        reset = 1'b0;
        tick();
        send_row(8'd5, 8'd6);
        send_row(8'd7, 8'd8);
        run_feed(8'd5, 8'd6, 8'd7, 8'd8);

        tick();
        tick();
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_systolic_input_skew

`default_nettype wire
